// File: rtl/symbol_streamer.sv
// Word FIFO feeding a 2-bit symbol serializer with valid/ready handshake and last marking.
// Optional SYMBOL_CHECKSUM_EN adds sym_csum, a mod-256 sum of accepted symbols.
module symbol_streamer #(
   parameter int WORD_LEN   = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_LEN    = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                wr_en,
   input  logic [WORD_LEN-1:0] wr_data,
   input  logic                wr_last,
   output logic                full,
   input  logic                start,
   output logic [1:0]          symbol,
   output logic                sym_valid,
   input  logic                sym_ready,
   output logic                sym_last,
   output logic                busy,
   output logic                done,
   output logic [CNT_LEN-1:0]  sym_count
`ifdef SYMBOL_CHECKSUM_EN
   ,
   output logic [7:0]          sym_csum
`endif
);

   // state | meaning
   // IDLE  | waiting for start
   // LOAD  | waiting for a word in the FIFO (underflow stall)
   // SHIFT | presenting symbols of the current word
   // DONE  | one-cycle completion pulse

   localparam int NSYM = WORD_LEN / 2;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int IW   = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic [WORD_LEN-1:0]   r_mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_mem_last;
   logic [AW:0]           r_wr_ptr, r_rd_ptr;
   logic [WORD_LEN-1:0]   r_shreg;
   logic                  r_word_last;
   logic [IW-1:0]         r_idx;
   logic [CNT_LEN-1:0]    r_count;

   logic w_empty, w_push, w_pop, w_accept, w_idx_end, w_clr;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push    = wr_en & ~full;
   assign w_idx_end = (r_idx == LAST_IDX);

   assign sym_valid = (r_state == S_SHIFT);
   assign w_accept  = sym_valid & sym_ready;
   assign symbol    = r_shreg[1:0];
   assign sym_last  = sym_valid & r_word_last & w_idx_end;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign sym_count = r_count;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem_data[i] <= '0;
         r_mem_last <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= wr_data;
            r_mem_last[r_wr_ptr[AW-1:0]] <= wr_last;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // End of a non-final word pops the next one on the accepting edge, so no bubble.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_LOAD;
               w_clr       = 1'b1;
            end
         end
         S_LOAD: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_accept && w_idx_end) begin
               if (r_word_last)   w_state_nxt = S_DONE;
               else if (!w_empty) w_pop       = 1'b1;
               else               w_state_nxt = S_LOAD;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_shreg     <= '0;
         r_word_last <= 1'b0;
         r_idx       <= '0;
      end else if (w_pop) begin
         r_shreg     <= r_mem_data[r_rd_ptr[AW-1:0]];
         r_word_last <= r_mem_last[r_rd_ptr[AW-1:0]];
         r_idx       <= '0;
      end else if (w_accept) begin
         r_shreg <= r_shreg >> 2;
         r_idx   <= r_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                                r_count <= '0;
      else if (w_clr)                          r_count <= '0;
      else if (w_accept && (r_count != '1))    r_count <= r_count + 1'b1;
   end

`ifdef SYMBOL_CHECKSUM_EN
   logic [7:0] r_csum;
   assign sym_csum = r_csum;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)          r_csum <= '0;
      else if (w_clr)    r_csum <= '0;
      else if (w_accept) r_csum <= r_csum + {6'b0, r_shreg[1:0]};
   end
`endif

endmodule
